// File: rtl/processor.sv
// Multi-cycle word-addressed processor: 16 GPRs, optional HI/LO mul/div, FSM FETCH/DECODE/EXEC/[MEM]/WB/HALT.
// Latency: 4 cycles per instruction, 5 for ld/st, plus one cycle per iMemRdy=0 cycle in FETCH or MEM.
// Backpressure: FETCH and MEM hold address, data and strobe stable until iMemRdy=1.
// Ports: iClk/iRst (sync, active-high), oMemAddr/oMemData/oMemRead/oMemWrite to memory,
//        iMemData/iMemRdy from memory. Parameter START_PC is the reset PC.
// Optional feature: define PROCESSOR_MULDIV_EN to build mul, div, mfhi and mflo (otherwise they are nops).
module processor #(
  parameter logic [31:0] START_PC = 32'd0
) (
  input  logic        iClk,
  input  logic        iRst,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemData,
  input  logic [31:0] iMemData,
  input  logic        iMemRdy,
  output logic        oMemRead,
  output logic        oMemWrite
);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_HALT = 5'b11011;
`ifdef PROCESSOR_MULDIV_EN
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
`endif

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] gpr [16];
  logic [31:0] pc, ir, res;
  logic        take;
  logic [31:0] res_c;
  logic        take_c;
`ifdef PROCESSOR_MULDIV_EN
  logic [31:0] hi, lo;
  logic [63:0] hilo_res, hilo_c;
`endif

  // Instruction fields
  logic [4:0]  op;
  logic [3:0]  ra, rb, rc;
  logic [1:0]  c2;
  logic [31:0] imm, rav, rbv, rcv, ea;

  assign op  = ir[31:27];
  assign ra  = ir[26:23];
  assign rb  = ir[22:19];
  assign rc  = ir[18:15];
  assign c2  = ir[20:19];
  assign imm = {{13{ir[18]}}, ir[18:0]};
  assign rav = gpr[ra];
  assign rbv = gpr[rb];
  assign rcv = gpr[rc];
  // Only address math treats Rb=0 as literal zero; R0 is otherwise a normal register.
  assign ea  = imm + ((rb == 4'd0) ? 32'd0 : rbv);

  // Execute-stage results, registered at the end of EXEC and committed in WB.
  always_comb begin
    res_c  = '0;
    take_c = 1'b0;
`ifdef PROCESSOR_MULDIV_EN
    hilo_c = '0;
`endif
    case (op)
      OP_LDI:  res_c = ea;
      OP_ADD:  res_c = rbv + rcv;
      OP_SUB:  res_c = rbv - rcv;
      OP_AND:  res_c = rbv & rcv;
      OP_OR:   res_c = rbv | rcv;
      OP_ADDI: res_c = rbv + imm;
      OP_ANDI: res_c = rbv & imm;
      OP_ORI:  res_c = rbv | imm;
      OP_BR: begin
        // pc already points past the branch
        res_c = pc + imm;
        case (c2)
          2'b00:   take_c = (rav == 32'd0);
          2'b01:   take_c = (rav != 32'd0);
          2'b10:   take_c = ~rav[31];
          default: take_c = rav[31];
        endcase
      end
      OP_JR: begin
        res_c  = rav;
        take_c = 1'b1;
      end
`ifdef PROCESSOR_MULDIV_EN
      OP_MFHI: res_c = hi;
      OP_MFLO: res_c = lo;
      OP_MUL:  hilo_c = $signed({{32{rav[31]}}, rav}) * $signed({{32{rbv[31]}}, rbv});
      OP_DIV: begin
        if (rbv == 32'd0) hilo_c = {rav, 32'hFFFF_FFFF};
        else              hilo_c = {32'($signed(rav) % $signed(rbv)), 32'($signed(rav) / $signed(rbv))};
      end
`endif
      default: ;
    endcase
  end

  // Next state and memory interface. Strobes are gated by iRst so an in-flight
  // access is dropped in the very cycle reset is asserted.
  always_comb begin
    state_nxt = state;
    oMemAddr  = '0;
    oMemData  = '0;
    oMemRead  = 1'b0;
    oMemWrite = 1'b0;
    case (state)
      FETCH: begin
        oMemAddr = pc;
        oMemRead = 1'b1;
        if (iMemRdy) state_nxt = DECODE;
      end
      DECODE:  state_nxt = (op == OP_HALT) ? HALT : EXEC;
      EXEC:    state_nxt = (op == OP_LD || op == OP_ST) ? MEM : WB;
      MEM: begin
        oMemAddr  = ea;
        oMemRead  = (op == OP_LD);
        oMemWrite = (op == OP_ST);
        oMemData  = (op == OP_ST) ? rav : 32'd0;
        if (iMemRdy) state_nxt = WB;
      end
      WB:      state_nxt = FETCH;
      default: state_nxt = HALT;
    endcase
    if (iRst) begin
      oMemAddr  = '0;
      oMemData  = '0;
      oMemRead  = 1'b0;
      oMemWrite = 1'b0;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= FETCH;
      pc    <= START_PC;
      ir    <= '0;
      res   <= '0;
      take  <= 1'b0;
      for (int i = 0; i < 16; i++) gpr[i] <= '0;
`ifdef PROCESSOR_MULDIV_EN
      hi       <= '0;
      lo       <= '0;
      hilo_res <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        FETCH: if (iMemRdy) begin
          ir <= iMemData;
          pc <= pc + 32'd1;
        end
        EXEC: begin
          res  <= res_c;
          take <= take_c;
`ifdef PROCESSOR_MULDIV_EN
          hilo_res <= hilo_c;
`endif
        end
        MEM: if (op == OP_LD && iMemRdy) res <= iMemData;
        WB: begin
          case (op)
            OP_LD, OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ADDI, OP_ANDI, OP_ORI: gpr[ra] <= res;
            OP_BR, OP_JR: if (take) pc <= res;
`ifdef PROCESSOR_MULDIV_EN
            OP_MFHI, OP_MFLO: gpr[ra] <= res;
            OP_MUL, OP_DIV:   {hi, lo} <= hilo_res;
`endif
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_processor.sv
// Testbench for processor: directed programs plus random programs checked by an
// instruction-level reference model; store traffic is checked by a scoreboard monitor.
module tb_processor;

  localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010, ADD = 5'b00011,
                         SUB = 5'b00100, AND_ = 5'b00101, OR_ = 5'b00110, ADDI = 5'b01100,
                         ANDI = 5'b01101, ORI = 5'b01110, DIV = 5'b01111, MUL = 5'b10000,
                         BR = 5'b10011, JR = 5'b10100, MFHI = 5'b11000, MFLO = 5'b11001,
                         NOP = 5'b11010, HALT = 5'b11011;

  logic        iClk = 1'b0;
  logic        iRst;
  logic [31:0] oMemAddr, oMemData, iMemData;
  logic        iMemRdy, oMemRead, oMemWrite;

  processor #(.START_PC(32'd0)) dut (
    .iClk(iClk), .iRst(iRst), .oMemAddr(oMemAddr), .oMemData(oMemData),
    .iMemData(iMemData), .iMemRdy(iMemRdy), .oMemRead(oMemRead), .oMemWrite(oMemWrite)
  );

  always #5 iClk = ~iClk;

  logic [31:0] mem [256];
  assign iMemData = mem[oMemAddr[7:0]];

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t         exp_q [$];
  logic [31:0] rd_log [$];
  int          checks, errors;
  bit          rnd_rdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ri(input logic [4:0] op, input int ra, input int rb, input int c);
    return {op, 4'(ra), 4'(rb), 19'(c)};
  endfunction

  function automatic logic [31:0] rr(input logic [4:0] op, input int ra, input int rb, input int rc);
    return {op, 4'(ra), 4'(rb), 4'(rc), 15'd0};
  endfunction

  // Memory-side monitor: scoreboard for writes, log of completed reads.
  initial forever begin
    @(negedge iClk);
    if (oMemRead || oMemWrite) check("one_strobe", {31'd0, oMemRead & oMemWrite}, 32'd0);
    if (oMemWrite && iMemRdy) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr %h data %h, none expected", oMemAddr, oMemData);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", oMemAddr, e.a);
        check("wr_data", oMemData, e.d);
      end
      mem[oMemAddr[7:0]] = oMemData;
    end
    if (oMemRead && iMemRdy) rd_log.push_back(oMemAddr);
  end

  // Random memory-ready generator
  initial forever begin
    @(posedge iClk); #1;
    if (rnd_rdy) iMemRdy = ($urandom_range(0, 3) != 0);
  end

  // Instruction-level reference model: runs the program in mem from address 0
  // and queues every store it performs.
  task automatic iss();
    logic [31:0] r [16];
    logic [31:0] m [256];
    logic [31:0] hi, lo, pc, ir, imm, ea;
    logic [3:0]  a, b, c;
    bit          t;
    for (int i = 0; i < 16; i++) r[i] = 0;
    for (int i = 0; i < 256; i++) m[i] = mem[i];
    hi = 0; lo = 0; pc = 0;
    for (int step = 0; step < 2000; step++) begin
      ir  = m[pc[7:0]];
      pc  = pc + 1;
      a   = ir[26:23]; b = ir[22:19]; c = ir[18:15];
      imm = {{13{ir[18]}}, ir[18:0]};
      ea  = imm + ((b == 0) ? 32'd0 : r[b]);
      case (ir[31:27])
        LD:   r[a] = m[ea[7:0]];
        LDI:  r[a] = ea;
        ST:   begin m[ea[7:0]] = r[a]; exp_q.push_back('{ea, r[a]}); end
        ADD:  r[a] = r[b] + r[c];
        SUB:  r[a] = r[b] - r[c];
        AND_: r[a] = r[b] & r[c];
        OR_:  r[a] = r[b] | r[c];
        ADDI: r[a] = r[b] + imm;
        ANDI: r[a] = r[b] & imm;
        ORI:  r[a] = r[b] | imm;
        BR: begin
          case (ir[20:19])
            2'b00:   t = ($signed(r[a]) == 0);
            2'b01:   t = ($signed(r[a]) != 0);
            2'b10:   t = ($signed(r[a]) >= 0);
            default: t = ($signed(r[a]) < 0);
          endcase
          if (t) pc = pc + imm;
        end
        JR:   pc = r[a];
        HALT: return;
`ifdef PROCESSOR_MULDIV_EN
        MUL: begin
          longint sa, sb, p;
          sa = $signed(r[a]); sb = $signed(r[b]);
          p = sa * sb;
          hi = p[63:32]; lo = p[31:0];
        end
        DIV: begin
          longint sa, sb, q, rem;
          sa = $signed(r[a]); sb = $signed(r[b]);
          if (sb == 0) begin lo = 32'hFFFF_FFFF; hi = r[a]; end
          else begin
            q = sa / sb; rem = sa - q * sb;
            lo = q[31:0]; hi = rem[31:0];
          end
        end
        MFHI: r[a] = hi;
        MFLO: r[a] = lo;
`endif
        default: ;
      endcase
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
  endtask

  task automatic do_reset();
    @(posedge iClk); #1;
    iRst = 1'b1;
    @(negedge iClk);
    check("rst_read", {31'd0, oMemRead}, 32'd0);
    check("rst_write", {31'd0, oMemWrite}, 32'd0);
    check("rst_addr", oMemAddr, 32'd0);
    check("rst_data", oMemData, 32'd0);
    @(posedge iClk); #1;
    rd_log.delete();
    iRst = 1'b0;
  endtask

  // Wait for the halt signature (8 strobe-free cycles), then confirm it stays quiet.
  task automatic run_to_halt(input string name);
    int idle, cyc, strobes;
    idle = 0; cyc = 0; strobes = 0;
    while (idle < 8 && cyc < 3000) begin
      @(negedge iClk);
      cyc++;
      if (!oMemRead && !oMemWrite) idle++; else idle = 0;
    end
    if (idle < 8) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no halt after %0d cycles", name, cyc);
    end
    repeat (16) begin
      @(negedge iClk);
      if (oMemRead || oMemWrite) strobes++;
    end
    check({name, "_halt_quiet"}, strobes, 0);
    check({name, "_pending_wr"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    checks = 0; errors = 0;
    iRst = 1'b1; iMemRdy = 1'b1; rnd_rdy = 0;
    clear_mem();

    // Fetch stall: ready held low 3 cycles after reset.
    mem[0] = ri(NOP, 0, 0, 0); mem[1] = ri(NOP, 0, 0, 0); mem[2] = ri(HALT, 0, 0, 0);
    iMemRdy = 1'b0;
    do_reset();
    repeat (3) begin
      @(negedge iClk);
      check("stall_read", {31'd0, oMemRead}, 32'd1);
      check("stall_addr", oMemAddr, 32'd0);
      @(posedge iClk); #1;
    end
    iMemRdy = 1'b1;
    run_to_halt("stall");
    check("stall_nfetch", rd_log.size(), 3);
    if (rd_log.size() == 3) begin
      check("stall_f0", rd_log[0], 32'd0);
      check("stall_f1", rd_log[1], 32'd1);
      check("stall_f2", rd_log[2], 32'd2);
    end

    // mul program: 5+5=10, 10*5=50
    clear_mem();
    mem[0] = ri(LD, 1, 0, 20);  mem[1] = ri(ADDI, 1, 1, 5); mem[2] = ri(LD, 2, 0, 21);
    mem[3] = rr(MUL, 2, 1, 0);  mem[4] = ri(MFLO, 3, 0, 0); mem[5] = ri(ST, 3, 0, 2);
    mem[6] = ri(HALT, 0, 0, 0); mem[20] = 32'd5; mem[21] = 32'd5;
`ifdef PROCESSOR_MULDIV_EN
    exp_q.push_back('{32'd2, 32'd50});
`else
    exp_q.push_back('{32'd2, 32'd0});
`endif
    do_reset();
    run_to_halt("mul");

    // div program: -7/2 and divide by r0
    clear_mem();
    mem[0]  = ri(LDI, 1, 0, -7);  mem[1]  = ri(LDI, 2, 0, 2);    mem[2]  = rr(DIV, 1, 2, 0);
    mem[3]  = ri(MFLO, 3, 0, 0);  mem[4]  = ri(MFHI, 4, 0, 0);   mem[5]  = ri(ST, 3, 0, 64);
    mem[6]  = ri(ST, 4, 0, 65);   mem[7]  = rr(DIV, 1, 0, 0);    mem[8]  = ri(MFLO, 5, 0, 0);
    mem[9]  = ri(MFHI, 6, 0, 0);  mem[10] = ri(ST, 5, 0, 66);    mem[11] = ri(ST, 6, 0, 67);
    mem[12] = ri(HALT, 0, 0, 0);
`ifdef PROCESSOR_MULDIV_EN
    exp_q.push_back('{32'd64, -32'sd3}); exp_q.push_back('{32'd65, -32'sd1});
    exp_q.push_back('{32'd66, 32'hFFFF_FFFF}); exp_q.push_back('{32'd67, -32'sd7});
`else
    exp_q.push_back('{32'd64, 32'd0}); exp_q.push_back('{32'd65, 32'd0});
    exp_q.push_back('{32'd66, 32'd0}); exp_q.push_back('{32'd67, 32'd0});
`endif
    do_reset();
    run_to_halt("div");

    // Branch taken on r4==0 skips two stores, then jr over another store to halt.
    clear_mem();
    mem[0] = ri(BR, 4, 0, 2);   mem[1] = ri(ST, 0, 0, 16); mem[2] = ri(ST, 0, 0, 17);
    mem[3] = ri(LDI, 5, 0, 6);  mem[4] = ri(JR, 5, 0, 0);  mem[5] = ri(ST, 0, 0, 18);
    mem[6] = ri(HALT, 0, 0, 0);
    do_reset();
    run_to_halt("br");
    check("br_nfetch", rd_log.size(), 4);
    if (rd_log.size() == 4) begin
      check("br_f1", rd_log[1], 32'd3);
      check("br_f2", rd_log[2], 32'd4);
      check("br_f3", rd_log[3], 32'd6);
    end

    // Reset during a store's MEM cycle: the aborted store must not happen.
    clear_mem();
    mem[0] = ri(LDI, 1, 0, 7); mem[1] = ri(ST, 1, 0, 80); mem[2] = ri(HALT, 0, 0, 0);
    exp_q.push_back('{32'd80, 32'd7});   // only the rerun after reset stores
    do_reset();
    begin
      int n;
      n = 0;
      while (!oMemWrite && n < 40) begin @(posedge iClk); #1; n++; end
      if (!oMemWrite) begin
        checks++; errors++;
        $display("FAIL abort_no_store: store strobe never seen");
      end
    end
    iRst = 1'b1;
    @(negedge iClk);
    check("abort_write", {31'd0, oMemWrite}, 32'd0);
    @(posedge iClk); #1;
    rd_log.delete();
    iRst = 1'b0;
    run_to_halt("abort");
    check("abort_refetch", (rd_log.size() > 0) ? rd_log[0] : 32'hDEAD_BEEF, 32'd0);

    // Random programs against the reference model, with random ready stalls.
    for (int p = 0; p < 25; p++) begin
      clear_mem();
      for (int i = 0; i < 12; i++) begin
        int k, a, b, c;
        k = $urandom_range(0, 14);
        a = $urandom_range(0, 15); b = $urandom_range(0, 15); c = $urandom_range(0, 15);
        case (k)
          0:  mem[i] = ri(LDI, a, b, $urandom_range(0, 524287));
          1:  mem[i] = rr(ADD, a, b, c);
          2:  mem[i] = rr(SUB, a, b, c);
          3:  mem[i] = rr(AND_, a, b, c);
          4:  mem[i] = rr(OR_, a, b, c);
          5:  mem[i] = ri(ADDI, a, b, $urandom_range(0, 524287));
          6:  mem[i] = ri(ANDI, a, b, $urandom_range(0, 524287));
          7:  mem[i] = ri(ORI, a, b, $urandom_range(0, 524287));
          8:  mem[i] = rr(MUL, a, b, 0);
          9:  mem[i] = rr(DIV, a, b, 0);
          10: mem[i] = ri(($urandom_range(0, 1) != 0) ? MFHI : MFLO, a, 0, 0);
          11: mem[i] = ri(LD, a, 0, 64 + $urandom_range(0, 15));
          12: mem[i] = ri(ST, a, 0, 64 + $urandom_range(0, 15));
          13: mem[i] = ri(BR, a, $urandom_range(0, 3), $urandom_range(0, 2));
          default: mem[i] = ri(($urandom_range(0, 1) != 0) ? NOP : 5'b00111, a, b, 0);
        endcase
      end
      for (int i = 0; i < 16; i++) mem[12 + i] = ri(ST, i, 0, 128 + i);
      mem[28] = ri(HALT, 0, 0, 0);
      for (int i = 64; i < 80; i++) mem[i] = $urandom;
      exp_q.delete();
      iss();
      rnd_rdy = 1;
      do_reset();
      run_to_halt("rand");
      rnd_rdy = 0;
      @(posedge iClk); #1;
      iMemRdy = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/processor.md
PROCESSOR -- requirements
Module: processor

Interface
REQ-001 SHALL have parameter START_PC, default 32'd0: word address loaded into PC on reset.
REQ-002 SHALL have port iClk, input, 1: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port iRst, input, 1: one clock; reset is synchronous and active-high.
REQ-004 SHALL have port oMemAddr, output, 32: word address for fetch, load or store.
REQ-005 SHALL have port oMemData, output, 32: store data.
REQ-006 SHALL have port iMemData, input, 32: instruction or load data.
REQ-007 SHALL have port iMemRdy, input, 1: memory ready; completes the current access.
REQ-008 SHALL have port oMemRead, output, 1: read strobe.
REQ-009 SHALL have port oMemWrite, output, 1: write strobe.

Function
REQ-010 SHALL hold 16 32-bit GPRs R0-R15, 32-bit HI and LO, a 32-bit PC and a 32-bit IR.
- Memory is word-addressed.
- Fields: opcode[31:27], Ra[26:23], Rb[22:19], Rc[18:15], C[18:0] sign-extended to 32 bits.
REQ-011 SHALL run FSM FETCH -> DECODE -> EXEC -> [MEM] -> WB -> FETCH, plus HALT.
- MEM is entered only for ld and st.
- FETCH waits while iMemRdy=0.
REQ-012 SHALL, in FETCH:
- drive oMemAddr=PC and oMemRead=1;
- on the edge with iMemRdy=1, load IR<=iMemData and PC<=PC+1.
REQ-013 SHALL, with iMemRdy tied 1, complete ALU, mul/div, mfhi/mflo, branch and nop in 4 cycles, and ld/st in 5 cycles.
REQ-014 SHALL, in MEM:
- drive oMemAddr=EA, where EA=C+(Rb==0 ? 0 : R[Rb]);
- ld: oMemRead=1; capture iMemData on the edge with iMemRdy=1.
- st: oMemWrite=1 with oMemData=R[Ra].
- Address, data and strobe change on the same edge and stay stable until iMemRdy=1.
REQ-015 SHALL keep exactly one of oMemRead/oMemWrite high during an access, and both low in DECODE, EXEC, WB and HALT.
REQ-016 SHALL implement opcodes:
- 00000 ld: R[Ra]=M[EA]
- 00001 ldi: R[Ra]=EA
- 00010 st: M[EA]=R[Ra]
- 00011 add, 00100 sub, 00101 and, 00110 or: R[Ra]=R[Rb] op R[Rc]
- 01100 addi, 01101 andi, 01110 ori: R[Ra]=R[Rb] op C
- 10011 br: C2=IR[20:19]; 00 zero, 01 nonzero, 10 >=0, 11 <0, tested on R[Ra]; if true PC=PC+C (PC already incremented)
- 10100 jr: PC=R[Ra]
- 11010 nop
- 11011 halt: enter HALT
- any other opcode behaves as nop
REQ-017 SHALL implement mul/div (under MULDIV_EN):
- 10000 mul: {HI,LO}=signed R[Ra]*R[Rb] (64-bit).
- 01111 div: LO=signed R[Ra]/R[Rb] truncated toward zero; HI=remainder with the sign of the dividend.
- Divide by zero: LO=32'hFFFFFFFF, HI=R[Ra].
- 11000 mfhi: R[Ra]=HI.
- 11001 mflo: R[Ra]=LO.
REQ-018 SHALL wrap all 32-bit arithmetic modulo 2^32, with no flags or traps.
REQ-019 SHALL write registers only in WB, and each instruction writes at most one GPR (or HI/LO).
REQ-020 SHALL treat R0 as a normal writable register; only ld/st/ldi address math substitutes 0 for Rb=0.
REQ-021 SHALL remain in HALT until reset, with no memory strobes.

Reset
REQ-022 SHALL, on a rising iClk edge with iRst=1:
- set PC=START_PC and IR=0;
- clear all GPRs, HI and LO;
- set FSM=FETCH;
- drive oMemRead, oMemWrite, oMemAddr and oMemData to 0.
REQ-023 SHALL abort any in-flight access immediately when iRst is asserted mid-instruction, with no register or memory write from that instruction.
REQ-024 SHALL begin the first fetch, at START_PC, in the first cycle after iRst deasserts.

Configuration
REQ-025 SHALL use macro PROCESSOR_MULDIV_EN:
- Defined: mul, div, mfhi and mflo behave per REQ-017.
- Undefined: no multiplier or divider is synthesised, those opcodes execute as nop, and HI/LO stay 0.

Verification
REQ-026 SHALL check the mul program, with M[20]=5 and M[21]=5:
- Program: ld r1,20(r0); addi r1,r1,5; ld r2,21(r0); mul r2,r1; mflo r3; st r3,2(r0).
- Required: a single write to addr 2 with data 50.
REQ-027 SHALL check div: r1=-7, r2=2, div r1,r2 -> LO=-3, HI=-1; div by r0=0 -> LO=32'hFFFFFFFF, HI=r1.
REQ-028 SHALL check iRst pulsed during a st's MEM cycle: no write occurs, and the next fetch is at START_PC.
REQ-029 SHALL check iMemRdy held low for 3 cycles during fetch: oMemRead and oMemAddr stay stable, and the PC advances only after ready.
REQ-030 SHALL check branch: r4=0, br zero with C=+2 -> the next fetch address is PC+3; halt -> no further strobes.
REQ-031 SHALL check the build without PROCESSOR_MULDIV_EN: the REQ-026 program stores 0 to addr 2.
